// File: rtl/relu_maxpool2x2.sv
// 2x2 non-overlapping max-pool over a Q16.16 map read from M1, written to M2.
// Define RELU_POOL_RELU_EN to clamp negative maxima to zero before writing.
module relu_maxpool2x2 #(
    parameter int unsigned IN_W     = 26,
    parameter logic [31:0] IN_BASE  = 32'd0,
    parameter logic [31:0] OUT_BASE = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        finish,
    output logic        M1_R_req,
    output logic [31:0] M1_addr,
    input  logic [31:0] M1_R_data,
    output logic [3:0]  M1_W_req,
    output logic [31:0] M1_W_data,
    output logic        M2_R_req,
    output logic [31:0] M2_addr,
    input  logic [31:0] M2_R_data,
    output logic [3:0]  M2_W_req,
    output logic [31:0] M2_W_data
);

    localparam int unsigned HalfW   = IN_W / 2;
    localparam int unsigned OutCnt  = HalfW * HalfW;
    localparam logic [31:0] LastK   = 32'(OutCnt - 1);
    localparam logic [31:0] LastCol = 32'(HalfW - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCap,
        StCmp,
        StWr,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] k_q, k_d;
    logic [31:0] row_q, row_d;
    logic [31:0] col_q, col_d;
    logic [1:0]  t_q, t_d;
    logic [31:0] mx_q, mx_d;
    logic        finish_q, finish_d;
    logic        m1_req_q, m1_req_d;
    logic [31:0] m1_addr_q, m1_addr_d;
    logic [3:0]  m2_wreq_q, m2_wreq_d;
    logic [31:0] m2_addr_q, m2_addr_d;
    logic [31:0] m2_wdata_q, m2_wdata_d;

    logic [31:0] rd_row;
    logic [31:0] rd_col;
    logic [31:0] rd_addr;
    logic        unused_m2_rdata;

    // Row/column kept as counters so no divider is needed for k / (IN_W/2).
    assign rd_row  = (row_q << 1) | {31'd0, t_q[1]};
    assign rd_col  = (col_q << 1) | {31'd0, t_q[0]};
    assign rd_addr = IN_BASE + (((rd_row * IN_W) + rd_col) << 2);

    assign unused_m2_rdata = ^M2_R_data;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        row_d      = row_q;
        col_d      = col_q;
        t_d        = t_q;
        mx_d       = mx_q;
        finish_d   = finish_q;
        m1_req_d   = m1_req_q;
        m1_addr_d  = m1_addr_q;
        m2_wreq_d  = 4'd0;
        m2_addr_d  = m2_addr_q;
        m2_wdata_d = m2_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    k_d      = 32'd0;
                    row_d    = 32'd0;
                    col_d    = 32'd0;
                    t_d      = 2'd0;
                    finish_d = 1'b0;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                m1_req_d  = 1'b1;
                m1_addr_d = rd_addr;
                state_d   = StWait;
            end
            StWait: begin
                state_d = StCap;
            end
            StCap: begin
                m1_req_d = 1'b0;
                if (t_q == 2'd0) begin
                    mx_d = M1_R_data;
                end else if ($signed(M1_R_data) > $signed(mx_q)) begin
                    mx_d = M1_R_data;
                end
                if (t_q != 2'd3) begin
                    t_d     = t_q + 2'd1;
                    state_d = StIssue;
                end else begin
                    state_d = StCmp;
                end
            end
            StCmp: begin
`ifdef RELU_POOL_RELU_EN
                mx_d = mx_q[31] ? 32'd0 : mx_q;
`else
                mx_d = mx_q;
`endif
                t_d     = 2'd0;
                state_d = StWr;
            end
            StWr: begin
                m2_wreq_d  = 4'b1111;
                m2_addr_d  = OUT_BASE + (k_q << 2);
                m2_wdata_d = mx_q;
                if (k_q == LastK) begin
                    state_d = StDone;
                end else begin
                    k_d = k_q + 32'd1;
                    if (col_q == LastCol) begin
                        col_d = 32'd0;
                        row_d = row_q + 32'd1;
                    end else begin
                        col_d = col_q + 32'd1;
                    end
                    state_d = StIssue;
                end
            end
            StDone: begin
                finish_d = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            k_q        <= 32'd0;
            row_q      <= 32'd0;
            col_q      <= 32'd0;
            t_q        <= 2'd0;
            mx_q       <= 32'd0;
            finish_q   <= 1'b0;
            m1_req_q   <= 1'b0;
            m1_addr_q  <= 32'd0;
            m2_wreq_q  <= 4'd0;
            m2_addr_q  <= 32'd0;
            m2_wdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            row_q      <= row_d;
            col_q      <= col_d;
            t_q        <= t_d;
            mx_q       <= mx_d;
            finish_q   <= finish_d;
            m1_req_q   <= m1_req_d;
            m1_addr_q  <= m1_addr_d;
            m2_wreq_q  <= m2_wreq_d;
            m2_addr_q  <= m2_addr_d;
            m2_wdata_q <= m2_wdata_d;
        end
    end

    assign finish    = finish_q;
    assign M1_R_req  = m1_req_q;
    assign M1_addr   = m1_addr_q;
    assign M1_W_req  = 4'd0;
    assign M1_W_data = 32'd0;
    assign M2_R_req  = 1'b0;
    assign M2_addr   = m2_addr_q;
    assign M2_W_req  = m2_wreq_q;
    assign M2_W_data = m2_wdata_q;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Scoreboard bench for relu_maxpool2x2: latency-2 M1 model, M2 write monitor,
// protocol counters, mid-pass reset and start-while-busy scenarios.
module tb_relu_maxpool2x2;

    localparam int IN_W  = 26;
    localparam int NIN   = IN_W * IN_W;
    localparam int HALF  = IN_W / 2;
    localparam int NOUT  = HALF * HALF;
    localparam int FIN_E = 14 * NOUT + 1;

    logic        clk;
    logic        rst;
    logic        start;
    logic        finish;
    logic        M1_R_req;
    logic [31:0] M1_addr;
    logic [31:0] M1_R_data;
    logic [3:0]  M1_W_req;
    logic [31:0] M1_W_data;
    logic        M2_R_req;
    logic [31:0] M2_addr;
    logic [31:0] M2_R_data;
    logic [3:0]  M2_W_req;
    logic [31:0] M2_W_data;

    relu_maxpool2x2 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .finish    (finish),
        .M1_R_req  (M1_R_req),
        .M1_addr   (M1_addr),
        .M1_R_data (M1_R_data),
        .M1_W_req  (M1_W_req),
        .M1_W_data (M1_W_data),
        .M2_R_req  (M2_R_req),
        .M2_addr   (M2_addr),
        .M2_R_data (M2_R_data),
        .M2_W_req  (M2_W_req),
        .M2_W_data (M2_W_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int start_cyc = 0;

    logic [31:0] m1 [NIN];
    logic [31:0] m2 [NOUT];
    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_data_q [$];
    logic [31:0] rd_pipe;

    int n_reads  = 0;
    int n_wr     = 0;
    int run_len  = 0;
    int bad_run  = 0;
    int bad_misc = 0;
    int bad_ovl  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // M1 model: data for the address registered at edge N is valid after edge N+1.
    always @(posedge clk) begin
        if (M1_R_req && (int'(M1_addr >> 2) < NIN)) rd_pipe <= m1[int'(M1_addr >> 2)];
        else rd_pipe <= 32'hDEADBEEF;
    end
    assign M1_R_data = rd_pipe;

    always @(negedge clk) begin
        if (M1_W_req != 4'd0 || M2_R_req) bad_misc++;
        if (M1_R_req && M2_W_req != 4'd0) bad_ovl++;
        if (!rst) begin
            run_len = 0;
        end else if (M1_R_req) begin
            if (run_len == 0) n_reads++;
            run_len++;
        end else if (run_len != 0) begin
            if (run_len != 2) bad_run++;
            run_len = 0;
        end
        if (M2_W_req != 4'd0) begin
            n_wr++;
            check_eq("w_req", {28'd0, M2_W_req}, 32'hF);
            if (exp_addr_q.size() == 0) begin
                check_eq("w_unexpected", 32'd1, 32'd0);
            end else begin
                check_eq("w_addr", M2_addr, exp_addr_q.pop_front());
                check_eq("w_data", M2_W_data, exp_data_q.pop_front());
            end
            if (int'(M2_addr >> 2) < NOUT) m2[int'(M2_addr >> 2)] = M2_W_data;
        end
    end

    task automatic fill_ramp();
        for (int i = 0; i < NIN; i++) m1[i] = i << 16;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NIN; i++) m1[i] = $urandom;
    endtask

    task automatic set_window0(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [31:0] d);
        m1[0]        = a;
        m1[1]        = b;
        m1[IN_W]     = c;
        m1[IN_W + 1] = d;
    endtask

    task automatic push_expected();
        logic [31:0] v [4];
        logic [31:0] best;
        for (int k = 0; k < NOUT; k++) begin
            int r = k / HALF;
            int c = k % HALF;
            v[0] = m1[(2 * r) * IN_W + 2 * c];
            v[1] = m1[(2 * r) * IN_W + 2 * c + 1];
            v[2] = m1[(2 * r + 1) * IN_W + 2 * c];
            v[3] = m1[(2 * r + 1) * IN_W + 2 * c + 1];
            best = v[3];
            for (int j = 0; j < 3; j++) if ($signed(v[j]) > $signed(best)) best = v[j];
`ifdef RELU_POOL_RELU_EN
            if (best[31]) best = 32'd0;
`endif
            exp_addr_q.push_back(32'(k * 4));
            exp_data_q.push_back(best);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
        check_eq("finish_cleared", {31'd0, finish}, 32'd0);
    endtask

    task automatic run_pass(input bit busy);
        int r0 = n_reads;
        int w0 = n_wr;
        int b0 = bad_run + bad_misc + bad_ovl;
        int fe = -1;
        pulse_start();
        if (busy) begin
            while (cyc - start_cyc < 49) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < FIN_E + 100; i++) begin
            @(negedge clk);
            if (finish) begin
                fe = cyc - start_cyc;
                break;
            end
        end
        check_eq("finish_edge", 32'(fe), 32'(FIN_E));
        check_eq("read_count", 32'(n_reads - r0), 32'(NOUT * 4));
        check_eq("write_count", 32'(n_wr - w0), 32'(NOUT));
        check_eq("protocol_bad", 32'(bad_run + bad_misc + bad_ovl - b0), 32'd0);
        check_eq("queue_left", 32'(exp_addr_q.size()), 32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    initial begin
        int w0;
        rst       = 1'b0;
        start     = 1'b0;
        M2_R_data = 32'd0;
        #3;
        check_eq("rst_finish", {31'd0, finish}, 32'd0);
        check_eq("rst_m1_req", {31'd0, M1_R_req}, 32'd0);
        check_eq("rst_m1_addr", M1_addr, 32'd0);
        check_eq("rst_m2_wreq", {28'd0, M2_W_req}, 32'd0);
        check_eq("rst_m2_wdata", M2_W_data, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Ramp input, with a start re-pulse mid-pass that must be ignored.
        fill_ramp();
        push_expected();
        run_pass(1'b1);
        check_eq("ramp_m2_0", m2[0], 32'h001B0000);
        check_eq("ramp_m2_last", m2[NOUT - 1], 32'h02A30000);
        repeat (5) @(negedge clk);
        check_eq("finish_held", {31'd0, finish}, 32'd1);

        // All-negative window 0.
        fill_random();
        set_window0(32'hFFFF0000, 32'hFFFE0000, 32'hFFF00000, 32'hFFFF8000);
        push_expected();
        run_pass(1'b0);
`ifdef RELU_POOL_RELU_EN
        check_eq("neg_m2_0", m2[0], 32'h00000000);
`else
        check_eq("neg_m2_0", m2[0], 32'hFFFF8000);
`endif

        // Extreme values and ties.
        fill_random();
        set_window0(32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000);
        push_expected();
        run_pass(1'b0);
        check_eq("mixed_m2_0", m2[0], 32'h7FFFFFFF);

        // Asynchronous reset at edge 700: write k=49 is the last one allowed.
        fill_ramp();
        push_expected();
        w0 = n_wr;
        pulse_start();
        while (cyc - start_cyc < 700) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("mid_rst_m1_req", {31'd0, M1_R_req}, 32'd0);
        check_eq("mid_rst_m1_addr", M1_addr, 32'd0);
        check_eq("mid_rst_m2_wreq", {28'd0, M2_W_req}, 32'd0);
        check_eq("mid_rst_m2_addr", M2_addr, 32'd0);
        check_eq("mid_rst_m2_wdata", M2_W_data, 32'd0);
        check_eq("mid_rst_writes", 32'(n_wr - w0), 32'd50);
        w0 = n_wr;
        repeat (4) @(negedge clk);
        exp_addr_q.delete();
        exp_data_q.delete();
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("post_rst_writes", 32'(n_wr - w0), 32'd0);
        check_eq("post_rst_finish", {31'd0, finish}, 32'd0);

        // Full pass after the aborted one.
        push_expected();
        run_pass(1'b0);
        check_eq("rerun_m2_0", m2[0], 32'h001B0000);
        check_eq("rerun_m2_last", m2[NOUT - 1], 32'h02A30000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
